uart_rx_fifo: RTL

- Parametrised, buffered UART receive engine for the next-generation UART datapath.
- Recovers frames from the serial `rx` pin under a runtime frame format:
  - 5..DATA_W data bits
  - optional odd/even parity
  - 1 or 2 stop bits
  - MSB-first or LSB-first bit order
- Each frame is stored with its error flags in an internal FIFO and drained through a valid/ready interface.
- Sits between the pad-side `rx` line and the FPGA-side consumer, replacing the unbuffered single-word receive path.

---
 rtl/uart_rx_fifo.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: recovers frames under a runtime frame format and
// queues {frame_err, parity_err, data} entries in a show-ahead FIFO.
module uart_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CNT_W-1:0]                   cfg_baud_div,
  input  logic [3:0]                         cfg_data_bits,
  input  logic                               cfg_parity_en,
  input  logic                               cfg_odd_parity,
  input  logic                               cfg_two_stop,
  input  logic                               cfg_lsb_first,
  input  logic                               rx,
  output logic [DATA_W-1:0]                  rx_data,
  output logic                               rx_parity_err,
  output logic                               rx_frame_err,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overrun,
  input  logic                               overrun_clr,
  output logic                               rx_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = DATA_W + 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP1     = 3'd4;
  localparam logic [2:0] ST_STOP2     = 3'd5;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

  logic             rx_m, rx_s, rx_p;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_idx_q;
  logic [DATA_W-1:0] data_q;
  logic             par_err_q, frame_err_q;

  logic [CNT_W-1:0] sh_div_q;
  logic [3:0]       sh_bits_q;
  logic             sh_par_q, sh_odd_q, sh_two_q, sh_lsb_q;

  logic             start_edge_c, tick_c, push_c, fe_c, exp_par_c;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] head_q, head_d, payload_c;
  logic             pop_c, full_c, wr_en_c, ovr_set_c;

  // Metastability guard plus one history flop for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign start_edge_c = ~rx_s & rx_p;
  assign tick_c       = (cnt_q == '0);
  assign exp_par_c    = sh_odd_q ? ~^data_q : ^data_q;

  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    fe_c    = frame_err_q;
    case (state_q)
      ST_IDLE:   if (start_edge_c) state_d = ST_START;
      ST_START:  if (tick_c) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick_c && (bit_idx_q == sh_bits_q - 4'd1))
          state_d = sh_par_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (tick_c) state_d = ST_STOP1;
      ST_STOP1, ST_STOP2: begin
        if (tick_c) begin
          fe_c = frame_err_q | ~rx_s;
          if (state_q == ST_STOP1 && sh_two_q) begin
            state_d = ST_STOP2;
          end else begin
            push_c  = 1'b1;
            // A line still low after a bad stop is a break: swallow it once
            state_d = (fe_c && !rx_s) ? ST_WAIT_IDLE : ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      sh_div_q    <= '0;
      sh_bits_q   <= '0;
      sh_par_q    <= 1'b0;
      sh_odd_q    <= 1'b0;
      sh_two_q    <= 1'b0;
      sh_lsb_q    <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_busy <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && start_edge_c) begin
        cnt_q       <= cfg_baud_div >> 1;
        sh_div_q    <= cfg_baud_div;
        sh_bits_q   <= cfg_data_bits;
        sh_par_q    <= cfg_parity_en;
        sh_odd_q    <= cfg_odd_parity;
        sh_two_q    <= cfg_two_stop;
        sh_lsb_q    <= cfg_lsb_first;
        bit_idx_q   <= '0;
        data_q      <= '0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end else if (tick_c) begin
        cnt_q <= sh_div_q;
        case (state_q)
          ST_DATA: begin
            if (sh_lsb_q) data_q <= data_q | (DATA_W'(rx_s) << bit_idx_q);
            else          data_q <= {data_q[DATA_W-2:0], rx_s};
            bit_idx_q <= bit_idx_q + 4'd1;
          end
          ST_PARITY:          par_err_q   <= (rx_s != exp_par_c);
          ST_STOP1, ST_STOP2: frame_err_q <= fe_c;
          default: ;
        endcase
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts when a pop frees a slot
  always_comb begin
    pop_c     = (count_q != '0) & rx_ready;
    full_c    = (count_q == LVL_W'(FIFO_DEPTH));
    wr_en_c   = push_c & (~full_c | pop_c);
    ovr_set_c = push_c & full_c & ~pop_c;
    payload_c = {fe_c, par_err_q, data_q};
    rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    head_d    = '0;
    if (count_d != '0) begin
      if (wr_en_c && (wr_ptr_q == rd_ptr_d)) head_d = payload_c;
      else                                   head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= payload_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      rx_valid <= (count_d != '0);
      if (ovr_set_c)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign fifo_level = count_q;
  assign {rx_frame_err, rx_parity_err, rx_data} = head_q;

endmodule
